// File: rtl/adder_subtractor.sv
// -----------------------------------------------------------------------------
// adder_subtractor
//
// Purpose:
//   Registered WIDTH-bit adder/subtractor built as a ripple chain of full
//   adders. When S=1, every B bit is inverted and the chain's carry-in is 1,
//   so the chain computes A + ~B + 1 = A - B. Results and flags are captured
//   on a rising clk edge when EN=1. They hold their value when EN=0.
//
// Ports:
//   clk     in   1      clock; all state changes on its rising edge
//   rst_n   in   1      synchronous active-low reset; overrides EN
//   A       in   WIDTH  operand A (unsigned or two's complement)
//   B       in   WIDTH  operand B (unsigned or two's complement)
//   S       in   1      0 = A+B, 1 = A-B
//   EN      in   1      1 = capture a new result on this edge
//   ANSWER  out  WIDTH  registered result, modulo 2^WIDTH
//   COUT    out  1      registered carry out of the MSB
//                       (for subtract: 1 = no borrow)
//   OVF     out  1      registered two's-complement overflow flag
//   ZERO    out  1      registered flag, set when the result is all zeros
// -----------------------------------------------------------------------------
module adder_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  input  logic             EN,
  output logic [WIDTH-1:0] ANSWER,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  // Ripple chain: carry[i] is the carry into stage i.
  // carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;

  assign carry[0] = S;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign b_eff[gi]    = B[gi] ^ S;
      assign sum[gi]      = A[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi+1]  = (A[gi] & b_eff[gi]) | (carry[gi] & (A[gi] ^ b_eff[gi]));
    end
  endgenerate

  // Signed overflow happens when the carry into the sign bit differs from
  // the carry out of it.
  logic raw_ovf;
  logic raw_zero;
  assign raw_ovf  = carry[WIDTH-1] ^ carry[WIDTH];
  assign raw_zero = ~(|sum);

  // Output registers
  logic [WIDTH-1:0] answer_q, answer_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  always_comb begin
    answer_d = answer_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (EN) begin
      answer_d = sum;
      cout_d   = carry[WIDTH];
      ovf_d    = raw_ovf;
      zero_d   = raw_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      answer_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      answer_q <= answer_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign ANSWER = answer_q;
  assign COUT   = cout_q;
  assign OVF    = ovf_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// -----------------------------------------------------------------------------
// tb_adder_subtractor
//
// Self-checking bench for adder_subtractor at WIDTH=6.
//   - An arithmetic reference model tracks the expected output registers.
//     A compare process checks them against the DUT on every falling edge
//     after the first reset edge.
//   - Directed vectors are checked against hand-computed literal results.
//   - An exhaustive sweep covers both ops and all 64x64 operand pairs.
//     EN=0 stalls are inserted at random between captures.
// -----------------------------------------------------------------------------
module tb_adder_subtractor;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         s_in;
  logic         en_in;
  logic [W-1:0] answer;
  logic         cout;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;

  adder_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (a_in),
    .B      (b_in),
    .S      (s_in),
    .EN     (en_in),
    .ANSWER (answer),
    .COUT   (cout),
    .OVF    (ovf),
    .ZERO   (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic, no gate-level modelling.
  // Packed result layout is {answer[5:0], cout, ovf, zero}.
  function automatic logic [W+2:0] ref_calc(input int a, input int b, input bit s);
    int full, sa, sb, sr, ans;
    bit c, o, z;
    if (!s) begin
      full = a + b;
      c    = (full >= 64);
    end else begin
      full = a - b;
      c    = (a >= b);
    end
    ans = full & 63;
    sa  = (a >= 32) ? a - 64 : a;
    sb  = (b >= 32) ? b - 64 : b;
    sr  = s ? (sa - sb) : (sa + sb);
    o   = (sr > 31) || (sr < -32);
    z   = (ans == 0);
    return {ans[W-1:0], c, o, z};
  endfunction

  logic [W-1:0] exp_ans;
  logic         exp_cout, exp_ovf, exp_zero;
  bit           model_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_ans     <= '0;
      exp_cout    <= 1'b0;
      exp_ovf     <= 1'b0;
      exp_zero    <= 1'b0;
      model_valid <= 1'b1;
    end else if (en_in) begin
      {exp_ans, exp_cout, exp_ovf, exp_zero} <= ref_calc(int'(a_in), int'(b_in), s_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_answer", 32'(answer), 32'(exp_ans));
      chk("model_cout",   32'(cout),   32'(exp_cout));
      chk("model_ovf",    32'(ovf),    32'(exp_ovf));
      chk("model_zero",   32'(zero),   32'(exp_zero));
    end
  end

  // Drive one cycle of inputs on the falling edge.
  // Return just after the next rising edge.
  task automatic apply(input bit rn, input bit s, input int a, input int b, input bit en);
    @(negedge clk);
    rst_n = rn;
    s_in  = s;
    a_in  = W'(a);
    b_in  = W'(b);
    en_in = en;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int ans, input bit c, input bit o, input bit z);
    $display("txn %s: ANSWER=%0d COUT=%0b OVF=%0b ZERO=%0b", name, answer, cout, ovf, zero);
    chk({name, "_answer"}, 32'(answer), 32'(ans));
    chk({name, "_cout"},   32'(cout),   32'(c));
    chk({name, "_ovf"},    32'(ovf),    32'(o));
    chk({name, "_zero"},   32'(zero),   32'(z));
  endtask

  initial begin
    rst_n = 1'b0;
    s_in  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    en_in = 1'b0;

    // Reset takes priority over EN
    apply(0, 0, 5, 3, 1);
    lit("reset", 0, 0, 0, 0);

    apply(1, 1, 63, 46, 1);
    lit("sub_63_46", 17, 1, 0, 0);

    apply(1, 0, 63, 1, 1);
    lit("add_wrap_zero", 0, 1, 0, 1);

    apply(1, 0, 31, 1, 1);
    lit("add_ovf", 32, 0, 1, 0);

    apply(1, 1, 32, 1, 1);
    lit("sub_ovf", 31, 1, 1, 0);

    apply(1, 1, 0, 1, 1);
    lit("sub_borrow", 63, 0, 0, 0);

    // Hold: EN=0 for three edges with new operands present
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 10, 2, 0);
      lit("hold", 63, 0, 0, 0);
    end

    // S toggling between edges has no effect.
    // Only the value at the edge counts.
    @(negedge clk);
    s_in  = 1'b1;
    a_in  = 6'd20;
    b_in  = 6'd5;
    en_in = 1'b1;
    #2 s_in = 1'b0;
    #1 s_in = 1'b1;
    @(posedge clk);
    #1;
    lit("s_glitch", 15, 1, 0, 0);

    // Mid-stream reset discards the capture
    apply(0, 0, 5, 3, 1);
    lit("mid_reset", 0, 0, 0, 0);
    apply(1, 0, 5, 3, 0);
    lit("post_reset_idle", 0, 0, 0, 0);
    apply(1, 0, 5, 3, 1);
    lit("first_capture", 8, 0, 0, 0);

    // Exhaustive sweep with random stall cycles
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 64; a++) begin
        for (int b = 0; b < 64; b++) begin
          if ($urandom_range(0, 7) == 0)
            apply(1, bit'(s), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0);
          apply(1, bit'(s), a, b, 1);
        end
      end
      $display("txn sweep: S=%0d all 4096 operand pairs applied", s);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_subtractor.md
ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

Interface
REQ-001 Parameter: WIDTH, default 6, operand/result bit width (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-004 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 B  input  WIDTH  operand B, unsigned or two's complement.
REQ-006 S  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-007 EN  input  1  capture enable: 1 = register a new result this cycle, 0 = hold outputs.
REQ-008 ANSWER  output  WIDTH  registered result, modulo 2^WIDTH.
REQ-009 COUT  output  1  registered carry out of MSB; for subtract, 1 = no borrow, 0 = borrow.
REQ-010 OVF  output  1  registered two's-complement signed overflow flag.
REQ-011 ZERO  output  1  registered flag, 1 when the captured result is all zeros.

Function
REQ-012 Datapath SHALL be a WIDTH-stage ripple chain of full adders.
- Stage i operand: B[i] XOR S.
- Carry-in to stage 0: S.
- Subtract is therefore A + ~B + 1.
REQ-013 Raw result SHALL be sum[WIDTH-1:0], with carry = carry out of stage WIDTH-1; excess bits discarded (wrap-around).
REQ-014 Signed overflow SHALL be computed as carry into MSB XOR carry out of MSB.
- Add: operands same sign, result sign differs.
- Subtract: operands differ in sign, result sign differs from A.
REQ-015 Zero detect SHALL be the NOR of all raw result bits.
REQ-016 On a rising edge with rst_n=1 and EN=1, the raw result, carry, overflow and zero values SHALL be registered into ANSWER, COUT, OVF and ZERO.
REQ-017 On a rising edge with rst_n=1 and EN=0, all outputs SHALL hold their previous values.
REQ-018 Latency SHALL be exactly one clock: outputs reflect A, B and S sampled at the capturing edge.
REQ-019 Outputs SHALL change only on rising clk edges; no combinational path from inputs to outputs.
REQ-020 S toggling between edges SHALL have no effect except at the sampling edge.
- No stored mode.
- Each capture is independent of prior operations.
REQ-021 Unsigned interpretation: COUT=1 on add means the result exceeded 2^WIDTH-1; COUT=0 on subtract means A<B unsigned.
REQ-022 No X propagation from unused logic; all outputs SHALL be defined after the first reset edge.

Reset
REQ-023 A rising edge with rst_n=0 SHALL force ANSWER=0, COUT=0, OVF=0 and ZERO=0, regardless of EN.
REQ-024 Reset SHALL take priority over EN in the same cycle.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight capture; the first capture after release occurs on the first edge with rst_n=1 and EN=1.
REQ-026 Between power-up and the first reset edge, output values are unspecified.

Verification
REQ-027 rst_n=0, EN=1, A=5, B=3, S=0, one edge -> ANSWER=0, COUT=0, OVF=0, ZERO=0.
REQ-028 S=1, A=63, B=46, EN=1, one edge -> ANSWER=6'b010001 (17), COUT=1, OVF=0, ZERO=0.
REQ-029 S=0, A=63, B=1, EN=1, one edge -> ANSWER=0, COUT=1, OVF=0, ZERO=1.
REQ-030 S=0, A=31, B=1 -> ANSWER=6'b100000, COUT=0, OVF=1; then S=1, A=32, B=1 -> ANSWER=6'b011111, COUT=1, OVF=1.
REQ-031 S=1, A=0, B=1 -> ANSWER=6'b111111, COUT=0, OVF=0.
- Then EN=0 with A=10, B=2 for 3 edges -> outputs unchanged.
REQ-032 Randomized sweep of all 2x64x64 combinations at WIDTH=6 -> every output matches a (A±B) mod 64 reference with flags per REQ-013 to REQ-015, one cycle after capture.
